// File: rtl/conv_window_gen_pkg.sv
// ============================================================================
// Module   : conv_window_gen_pkg
// Brief    : Shared defaults and counter-width helper for the 3x3 conv path.
// Revision : 1.0
// ============================================================================
`default_nettype none

package conv_window_gen_pkg;

    localparam int c_DEF_WIDTH = 9;
    localparam int c_DEF_IMG_W = 28;
    localparam int c_DEF_IMG_H = 28;

    // Width of a position counter covering 0..n-1 (never narrower than 1 bit).
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv_line_buffer.sv
// ============================================================================
// Module   : conv_line_buffer
// Brief    : One-row RAM; returns the old word at i_addr and writes the new one.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_line_buffer
    import conv_window_gen_pkg::*;
#(
    parameter int DATA_W = 2 * c_DEF_WIDTH,
    parameter int DEPTH  = c_DEF_IMG_W
) (
    input  logic                        clk,
    input  logic                        i_we,
    input  logic [ctr_width(DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]           i_wdata,
    output logic [DATA_W-1:0]           o_rdata
);

    // Contents are not reset; the consumer masks stale rows.
    logic [DATA_W-1:0] r_mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

`default_nettype wire

// File: rtl/conv_window_gen.sv
// ============================================================================
// Module   : conv_window_gen
// Brief    : Raster pixel stream to 3x3 valid-convolution windows.
// Revision : 1.0
// ============================================================================
`default_nettype none

module conv_window_gen
    import conv_window_gen_pkg::*;
#(
    parameter int WIDTH = c_DEF_WIDTH,
    parameter int IMG_W = c_DEF_IMG_W,
    parameter int IMG_H = c_DEF_IMG_H
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] w00,
    output logic [WIDTH-1:0] w01,
    output logic [WIDTH-1:0] w02,
    output logic [WIDTH-1:0] w10,
    output logic [WIDTH-1:0] w11,
    output logic [WIDTH-1:0] w12,
    output logic [WIDTH-1:0] w20,
    output logic [WIDTH-1:0] w21,
    output logic [WIDTH-1:0] w22,
    output logic             out_valid,
    output logic             frame_done
);

    localparam int c_COL_W = ctr_width(IMG_W);
    localparam int c_ROW_W = ctr_width(IMG_H);
    localparam logic [c_COL_W-1:0] c_LAST_COL = c_COL_W'(IMG_W - 1);
    localparam logic [c_ROW_W-1:0] c_LAST_ROW = c_ROW_W'(IMG_H - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [c_COL_W-1:0] w_col;
    logic [c_ROW_W-1:0] w_row;
    logic               w_last_col;
    logic               w_last_row;
    logic               w_at_window;
    logic [WIDTH-1:0]   w_lb0;
    logic [WIDTH-1:0]   w_lb1;
    logic [2*WIDTH-1:0] w_lb_rdata;
    logic [2*WIDTH-1:0] w_lb_wdata;
    logic [WIDTH-1:0]   r_win [0:2][0:2];
    logic               r_out_valid;
    logic               r_frame_done;

    // Start-of-frame overrides the counters so this pixel lands at (0,0).
    assign w_col       = in_sof ? '0 : r_col;
    assign w_row       = in_sof ? '0 : r_row;
    assign w_last_col  = (w_col == c_LAST_COL);
    assign w_last_row  = (w_row == c_LAST_ROW);
    assign w_at_window = (w_row >= c_ROW_W'(2)) && (w_col >= c_COL_W'(2));

    // One RAM word carries both rows: {row-2, row-1}.
    assign {w_lb1, w_lb0} = w_lb_rdata;
    assign w_lb_wdata     = {w_lb0, in_data};

    conv_line_buffer #(
        .DATA_W (2 * WIDTH),
        .DEPTH  (IMG_W)
    ) u_line_buffer (
        .clk     (clk),
        .i_we    (in_valid),
        .i_addr  (w_col),
        .i_wdata (w_lb_wdata),
        .o_rdata (w_lb_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (in_valid) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_row + c_ROW_W'(1);
            end else begin
                r_col <= w_col + c_COL_W'(1);
                r_row <= w_row;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (in_valid) begin
            for (int r = 0; r < 3; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
            end
            r_win[0][2] <= w_lb1;
            r_win[1][2] <= w_lb0;
            r_win[2][2] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_out_valid  <= in_valid && w_at_window;
            r_frame_done <= in_valid && w_last_row && w_last_col;
        end
    end

    assign w00        = r_win[0][0];
    assign w01        = r_win[0][1];
    assign w02        = r_win[0][2];
    assign w10        = r_win[1][0];
    assign w11        = r_win[1][1];
    assign w12        = r_win[1][2];
    assign w20        = r_win[2][0];
    assign w21        = r_win[2][1];
    assign w22        = r_win[2][2];
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_conv_window_gen.sv
// ============================================================================
// Module   : tb_conv_window_gen
// Brief    : Self-checking bench for conv_window_gen on a 4x4 frame.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_window_gen;

    localparam int WIDTH = 9;
    localparam int IW    = 4;
    localparam int IH    = 4;
    localparam int NPIX  = IW * IH;
    localparam int WW    = 9 * WIDTH;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_sof;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] w00, w01, w02, w10, w11, w12, w20, w21, w22;
    logic             out_valid;
    logic             frame_done;

    conv_window_gen #(
        .WIDTH (WIDTH),
        .IMG_W (IW),
        .IMG_H (IH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .w00        (w00),
        .w01        (w01),
        .w02        (w02),
        .w10        (w10),
        .w11        (w11),
        .w12        (w12),
        .w20        (w20),
        .w21        (w21),
        .w22        (w22),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a frame store indexed by pixel position in the frame.
    logic [WIDTH-1:0] img [0:IH-1][0:IW-1];
    int               m_pos;
    logic [WW-1:0]    m_held;
    bit               m_held_known;

    typedef struct {
        logic             sof;
        logic [WIDTH-1:0] data;
        logic             exp_v;
        logic             exp_d;
        logic [WW-1:0]    exp_w;
    } vec_t;

    vec_t tbl [NPIX];

    function automatic logic [WW-1:0] dut_win();
        return {w00, w01, w02, w10, w11, w12, w20, w21, w22};
    endfunction

    function automatic logic [WW-1:0] ref_win(input int r, input int c);
        logic [WW-1:0] res;
        res = '0;
        for (int R = 0; R < 3; R++) begin
            for (int C = 0; C < 3; C++) begin
                res[(8 - (R * 3 + C)) * WIDTH +: WIDTH] = img[r - 2 + R][c - 2 + C];
            end
        end
        return res;
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b, expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_win(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_frame_done", frame_done, 1'b0);
        check_win("rst_window", dut_win(), '0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_win("rst_window_hold", dut_win(), '0);
        rst          = 1'b0;
        m_pos        = 0;
        m_held       = '0;
        m_held_known = 1'b1;
    endtask

    task automatic step(input logic v, input logic s, input logic [WIDTH-1:0] d);
        int            r, c;
        bit            ev, ed;
        logic [WW-1:0] ew;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        ev = 1'b0;
        ed = 1'b0;
        ew = m_held;
        if (v) begin
            if (s) m_pos = 0;
            r = m_pos / IW;
            c = m_pos % IW;
            img[r][c] = d;
            ev = (r >= 2) && (c >= 2);
            ed = (r == IH - 1) && (c == IW - 1);
            if (ev) begin
                ew           = ref_win(r, c);
                m_held       = ew;
                m_held_known = 1'b1;
            end else begin
                m_held_known = 1'b0;
            end
            m_pos = (m_pos + 1) % NPIX;
        end
        @(posedge clk);
        #1;
        check_bit("out_valid", out_valid, ev);
        check_bit("frame_done", frame_done, ed);
        if (ev || (!v && m_held_known)) check_win("window", dut_win(), ew);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;

        for (int i = 0; i < NPIX; i++) begin
            tbl[i].sof   = (i == 0);
            tbl[i].data  = WIDTH'(i + 1);
            tbl[i].exp_v = 1'b0;
            tbl[i].exp_d = 1'b0;
            tbl[i].exp_w = '0;
        end
        tbl[10].exp_v = 1'b1;
        tbl[10].exp_w = {9'd1, 9'd2, 9'd3, 9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11};
        tbl[11].exp_v = 1'b1;
        tbl[11].exp_w = {9'd2, 9'd3, 9'd4, 9'd6, 9'd7, 9'd8, 9'd10, 9'd11, 9'd12};
        tbl[14].exp_v = 1'b1;
        tbl[14].exp_w = {9'd5, 9'd6, 9'd7, 9'd9, 9'd10, 9'd11, 9'd13, 9'd14, 9'd15};
        tbl[15].exp_v = 1'b1;
        tbl[15].exp_d = 1'b1;
        tbl[15].exp_w = {9'd6, 9'd7, 9'd8, 9'd10, 9'd11, 9'd12, 9'd14, 9'd15, 9'd16};

        @(posedge clk);
        #1;
        do_reset();

        // Continuous frame against the fixed table
        for (int i = 0; i < NPIX; i++) begin
            in_valid = 1'b1;
            in_sof   = tbl[i].sof;
            in_data  = tbl[i].data;
            @(posedge clk);
            #1;
            check_bit("tbl_out_valid", out_valid, tbl[i].exp_v);
            check_bit("tbl_frame_done", frame_done, tbl[i].exp_d);
            if (tbl[i].exp_v) check_win("tbl_window", dut_win(), tbl[i].exp_w);
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        do_reset();

        // Same frame with an idle cycle after every pixel
        for (int i = 1; i <= NPIX; i++) begin
            step(1'b1, i == 1, WIDTH'(i));
            step(1'b0, 1'b0, WIDTH'($urandom));
        end

        // Two frames back to back, no sof on the second
        for (int i = 1; i <= NPIX; i++) step(1'b1, i == 1, WIDTH'(i));
        for (int i = 101; i <= 100 + NPIX; i++) step(1'b1, 1'b0, WIDTH'(i));

        // Reset mid-frame, then a full frame without sof
        for (int i = 1; i <= 9; i++) step(1'b1, i == 1, WIDTH'(i));
        do_reset();
        for (int i = 1; i <= NPIX; i++) step(1'b1, 1'b0, WIDTH'(i));

        // Partial frame resynchronised by sof
        for (int i = 1; i <= 6; i++) step(1'b1, i == 1, WIDTH'(i));
        for (int i = 1; i <= NPIX; i++) step(1'b1, i == 1, WIDTH'(i));

        // Random traffic with sparse sof and resets
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0, WIDTH'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Feeder for the 3*3 convolution datapath. Turns a raster-order pixel stream into 3*3 windows that the multiply/adder-tree stage consumes directly.
- Holds two line buffers plus a 3*3 register window.
- Emits one window per accepted pixel once a full 3*3 neighbourhood exists (valid convolution, no padding).
- Sits between the image/feature-map source and the conv units.

Parameters:
- WIDTH, 9, pixel bit width (matches the conv unit operand width).
- IMG_W, 28, pixels per row (>= 3).
- IMG_H, 28, rows per frame (>= 3).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  pixel strobe; block is always ready, no backpressure.
- in_sof  input  1  start of frame; sampled only when in_valid=1.
- in_data  input  WIDTH  pixel, raster order.
- w00..w22  output  WIDTH each (9 ports)  window; wRC = row R, column C; w00 is oldest row/column, w22 is newest pixel.
- out_valid  output  1  window strobe, one cycle per valid window.
- frame_done  output  1  one-cycle pulse with the last window of a frame.

Behaviour:
- Reset (async, rst=1): col=0, row=0, all wRC=0, out_valid=0, frame_done=0. Line-buffer RAM is not reset; stale contents are masked by the row gating below.
- Accept: each cycle with in_valid=1 accepts one pixel at position (row, col). Cycles with in_valid=0 change nothing: window holds, out_valid=0, frame_done=0.
- in_sof=1 with in_valid=1: the pixel is treated as (0,0) regardless of the counters. Counters continue from there. This resyncs a partial frame.
- Line buffers: lb0 holds row-1, lb1 holds row-2, depth IMG_W, addressed by col. On accept, read lb0[col] and lb1[col] (old values), then write lb1[col]<=lb0[col] and lb0[col]<=in_data.
- Window shift on accept:
  - wR0<=wR1 and wR1<=wR2 for R=0..2.
  - w02<=lb1[col], w12<=lb0[col], w22<=in_data.
- out_valid: registered, 1 in the cycle after an accepted pixel with row>=2 and col>=2; otherwise 0.
- Latency: 1 cycle from the accepted pixel to the window on the outputs.
- Window count: (IMG_W-2)*(IMG_H-2) windows per frame.
- Column wrap: at col=0 and col=1 the window mixes columns from the previous row. out_valid is suppressed there, so it does not matter.
- Counters:
  - col increments per accept and wraps at IMG_W-1 to 0; row increments on that wrap.
  - At (IMG_H-1, IMG_W-1), row and col both return to 0, so back-to-back frames need no gap and no in_sof.
- frame_done: 1 in the same cycle as out_valid for the window of pixel (IMG_H-1, IMG_W-1).
- Reset mid-frame: partial frame is discarded, next accepted pixel is (0,0), and no window appears until row 2, col 2 of the new frame.
- Widths: col is clog2(IMG_W) bits, row is clog2(IMG_H) bits. No arithmetic on pixel data.

Decomposition:
- Shared package: WIDTH default, IMG_W/IMG_H defaults, and a window-position helper (clog2-based counter widths). These are shared with the conv unit and the downstream accumulator.
- One natural sub-module: conv_line_buffer, a single-port-read/write RAM of depth IMG_W that returns the old word and writes the new one. Instantiate it twice, or once with a 2*WIDTH word holding {lb1, lb0}.
- The window registers and counters stay in the top level.

Test Plan:
- IMG_W=4, IMG_H=4, pixels 1..16 continuous, in_sof on pixel 1 -> exactly 4 out_valid pulses with these windows:
  - after pixel 11: (1,2,3,5,6,7,9,10,11)
  - after pixel 12: (2,3,4,6,7,8,10,11,12)
  - after pixel 15: (5,6,7,9,10,11,13,14,15)
  - after pixel 16: (6,7,8,10,11,12,14,15,16), with frame_done=1 in the same cycle.
- Same stream with in_valid=0 inserted every other cycle -> identical window values and order. Outputs hold during gaps; out_valid is never high twice for one pixel.
- Two frames back-to-back (1..16, then 101..116, no in_sof on the second) -> second frame's first window is (101,102,103,105,106,107,109,110,111). No window spans the two frames.
- Assert rst after pixel 9, then stream 1..16 -> no out_valid before the new pixel 11; windows match the first scenario.
- Send pixels 1..6, then in_sof with 1..16 -> output matches the first scenario exactly.
- Reset values: during and after rst, all wRC=0, out_valid=0, frame_done=0.
